case_convert_stream: RTL

CASE_CONVERT_STREAM -- requirements
Module: case_convert_stream

---
 rtl/case_convert_stream_if.sv | 19 +
 rtl/case_convert_stream.sv | 50 +++++
 2 files changed

// File: rtl/case_convert_stream_if.sv
// case_convert_stream_if: byte-lane stream handshake (upstream in_*, downstream out_*) for case_convert_stream
interface case_convert_stream_if #(
   parameter int LANES = 4
);
   logic               in_valid, in_ready, in_last;
   logic [8*LANES-1:0] in_data;
   logic [LANES-1:0]   in_keep;
   logic               out_valid, out_ready, out_last;
   logic [8*LANES-1:0] out_data;
   logic [LANES-1:0]   out_keep;
   modport master (
      output in_valid, in_data, in_keep, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );
   modport slave (
      input  in_valid, in_data, in_keep, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/case_convert_stream.sv
// case_convert_stream: single-register ASCII case converter on a byte-lane stream with a saturating changed-character counter
module case_convert_stream #(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           mode,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     conv_cnt,
   case_convert_stream_if.slave s
);
   logic [8*LANES-1:0] conv;
   logic [LANES-1:0]   lo, up, flip;
   logic [CNT_W:0]     sum;
   logic               accept;
   assign s.in_ready = !s.out_valid | s.out_ready;
   assign accept = s.in_valid & s.in_ready;
   always_comb begin
      conv = s.in_data;
      lo = '0;
      up = '0;
      flip = '0;
      sum = {1'b0, conv_cnt};
      for (int i = 0; i < LANES; i++) begin
         lo[i] = s.in_data[8*i +: 8] >= 8'h61 && s.in_data[8*i +: 8] <= 8'h7a;
         up[i] = s.in_data[8*i +: 8] >= 8'h41 && s.in_data[8*i +: 8] <= 8'h5a;
         flip[i] = s.in_keep[i] & (mode == 2'b01 ? lo[i] : mode == 2'b10 ? up[i] : mode == 2'b11 ? lo[i] | up[i] : 1'b0);
         conv[8*i+5] = s.in_data[8*i+5] ^ flip[i];
         sum = sum + {{CNT_W{1'b0}}, flip[i]};
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s.out_valid <= 1'b0;
         s.out_data <= '0;
         s.out_keep <= '0;
         s.out_last <= 1'b0;
         conv_cnt <= '0;
      end else begin
         if (s.in_ready) s.out_valid <= s.in_valid;
         if (accept) begin
            s.out_data <= conv;
            s.out_keep <= s.in_keep;
            s.out_last <= s.in_last;
         end
         conv_cnt <= cnt_clr ? '0 : !accept ? conv_cnt : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
   end
endmodule
